// File: rtl/clk_divider_multi.sv
// Multi-channel integer clock divider with glitch-free divisor updates,
// clean start/stop (drain to period end), per-period tick and shared sync restart.
module clk_divider_multi #(
  parameter int NCH   = 2,
  parameter int WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] div_i,
  input  logic [NCH-1:0]       en_i,
  input  logic                 sync_i,
  output logic [NCH-1:0]       clk_o,
  output logic [NCH-1:0]       tick_o,
  output logic [NCH-1:0]       run_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ndiv;
    logic [WIDTH-1:0] div_in;
    logic [WIDTH-1:0] neff_in;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] high;
    logic             last;
    logic             start;
    logic             stop;
    logic             clk_q;
    logic             tick_q;
    logic             run_q;

    // High phase is ceil(N/2), formed without the N+1 that could overflow WIDTH bits.
    always_comb begin
      div_in  = div_i[k*WIDTH +: WIDTH];
      neff_in = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
      cnt_inc = cnt + WIDTH'(1);
      high    = (ndiv >> 1) + {{(WIDTH-1){1'b0}}, ndiv[0]};
      last    = (cnt == ndiv - WIDTH'(1));
      start   = (sync_i && en_i[k]) ||
                (!sync_i && state == IDLE && en_i[k]) ||
                (!sync_i && state != IDLE && last && (en_i[k] || state == RUN));
      stop    = (sync_i && !en_i[k]) ||
                (!sync_i && state == IDLE && !en_i[k]) ||
                (!sync_i && state == DRAIN && last && !en_i[k]);
    end

    // A new period (with divisor reload) starts on enable, wrap or sync; a
    // channel that loses enable in RUN finishes one full period in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= IDLE;
        cnt    <= '0;
        ndiv   <= WIDTH'(2);
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        run_q  <= 1'b0;
      end else if (start) begin
        state  <= en_i[k] ? RUN : DRAIN;
        cnt    <= '0;
        ndiv   <= neff_in;
        clk_q  <= 1'b1;
        tick_q <= 1'b1;
        run_q  <= 1'b1;
      end else if (stop) begin
        state  <= IDLE;
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        run_q  <= 1'b0;
      end else begin
        state  <= en_i[k] ? RUN : DRAIN;
        cnt    <= cnt_inc;
        clk_q  <= (cnt_inc < high);
        tick_q <= 1'b0;
        run_q  <= 1'b1;
      end
    end

    assign clk_o[k]  = clk_q;
    assign tick_o[k] = tick_q;
    assign run_o[k]  = run_q;
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: directed scenarios plus randomized
// traffic, all checked against a period-level reference model.
module tb_clk_divider_multi;
  localparam int NCH   = 2;
  localparam int WIDTH = 13;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] div_i;
  logic [NCH-1:0]       en_i;
  logic                 sync_i;
  logic [NCH-1:0]       clk_o;
  logic [NCH-1:0]       tick_o;
  logic [NCH-1:0]       run_o;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: each channel is either inactive or somewhere inside a period.
  bit             act [NCH];
  bit             drn [NCH];
  int             pos [NCH];
  int             per [NCH];
  logic [NCH-1:0] exp_clk;
  logic [NCH-1:0] exp_tick;
  logic [NCH-1:0] exp_run;

  clk_divider_multi #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_i  (div_i),
    .en_i   (en_i),
    .sync_i (sync_i),
    .clk_o  (clk_o),
    .tick_o (tick_o),
    .run_o  (run_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      act[k] = 1'b0; drn[k] = 1'b0; pos[k] = 0; per[k] = 2;
    end
    exp_clk = '0; exp_tick = '0; exp_run = '0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < NCH; k++) begin
      int  d;
      int  n;
      bit  begin_period;
      d = int'(div_i[k*WIDTH +: WIDTH]);
      n = (d < 2) ? 2 : d;
      begin_period = 1'b0;
      if (sync_i) begin
        if (en_i[k]) begin_period = 1'b1;
        else begin act[k] = 1'b0; pos[k] = 0; end
      end else if (!act[k]) begin
        if (en_i[k]) begin_period = 1'b1;
      end else if (pos[k] == per[k] - 1) begin
        if (en_i[k] || !drn[k]) begin_period = 1'b1;
        else begin act[k] = 1'b0; pos[k] = 0; end
      end else begin
        pos[k] = pos[k] + 1;
        drn[k] = !en_i[k];
      end
      if (begin_period) begin
        act[k] = 1'b1; pos[k] = 0; per[k] = n; drn[k] = !en_i[k];
      end
      exp_tick[k] = begin_period;
      exp_run[k]  = act[k];
      exp_clk[k]  = act[k] && (pos[k] < (per[k] + 1) / 2);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en_i = '0; sync_i = 1'b0;
    div_i = {WIDTH'(2), WIDTH'(2)};
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_i = '0; sync_i = 1'b0; div_i = '0;
    model_reset();
    #3;
    compared++;
    if ({clk_o, tick_o, run_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got clk=%b tick=%b run=%b want all 0", clk_o, tick_o, run_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      compared++;
      if ({clk_o, tick_o, run_o} !== {exp_clk, exp_tick, exp_run}) begin
        mismatched++;
        $display("FAIL reset_idle cyc %0d: got clk=%b tick=%b run=%b want clk=%b tick=%b run=%b",
                 i, clk_o, tick_o, run_o, exp_clk, exp_tick, exp_run);
      end
    end
  endtask

  task automatic test_div4();
    logic [3:0] pat;
    pat = 4'b1100;
    do_reset();
    div_i = {WIDTH'(4), WIDTH'(4)};
    en_i  = 2'b11;
    for (int i = 0; i < 12; i++) begin
      step();
      compared++;
      if (clk_o[0] !== pat[3 - (i % 4)] || tick_o[0] !== (i % 4 == 0)) begin
        mismatched++;
        $display("FAIL div4_pattern cyc %0d: got clk=%b tick=%b want clk=%b tick=%b",
                 i, clk_o[0], tick_o[0], pat[3 - (i % 4)], (i % 4 == 0));
      end
      compared++;
      if ({clk_o, tick_o, run_o} !== {exp_clk, exp_tick, exp_run}) begin
        mismatched++;
        $display("FAIL div4_model cyc %0d: got clk=%b tick=%b run=%b want clk=%b tick=%b run=%b",
                 i, clk_o, tick_o, run_o, exp_clk, exp_tick, exp_run);
      end
    end
  endtask

  task automatic test_odd_and_clamp();
    logic [4:0] pat;
    pat = 5'b11100;
    do_reset();
    div_i = {WIDTH'(0), WIDTH'(5)};
    en_i  = 2'b11;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) div_i = {WIDTH'(1), WIDTH'(5)};
      step();
      compared++;
      if (clk_o[0] !== pat[4 - (i % 5)] || clk_o[1] !== (i % 2 == 0) ||
          tick_o[1] !== (i % 2 == 0)) begin
        mismatched++;
        $display("FAIL odd_clamp_pattern cyc %0d: got clk=%b tick=%b want ch0 clk=%b ch1 clk/tick=%b",
                 i, clk_o, tick_o, pat[4 - (i % 5)], (i % 2 == 0));
      end
      compared++;
      if ({clk_o, tick_o, run_o} !== {exp_clk, exp_tick, exp_run}) begin
        mismatched++;
        $display("FAIL odd_clamp_model cyc %0d: got clk=%b tick=%b run=%b want clk=%b tick=%b run=%b",
                 i, clk_o, tick_o, run_o, exp_clk, exp_tick, exp_run);
      end
    end
  endtask

  task automatic test_div_change();
    logic [9:0] pat;
    pat = 10'b1100111000;
    do_reset();
    div_i = {WIDTH'(4), WIDTH'(4)};
    en_i  = 2'b01;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) div_i = {WIDTH'(4), WIDTH'(6)};
      step();
      compared++;
      if (clk_o[0] !== pat[9 - i]) begin
        mismatched++;
        $display("FAIL div_change cyc %0d: got clk=%b want clk=%b", i, clk_o[0], pat[9 - i]);
      end
      compared++;
      if ({clk_o, tick_o, run_o} !== {exp_clk, exp_tick, exp_run}) begin
        mismatched++;
        $display("FAIL div_change_model cyc %0d: got clk=%b tick=%b run=%b want clk=%b tick=%b run=%b",
                 i, clk_o, tick_o, run_o, exp_clk, exp_tick, exp_run);
      end
    end
  endtask

  task automatic test_drain();
    do_reset();
    div_i = {WIDTH'(2), WIDTH'(6)};
    en_i  = 2'b01;
    step();
    en_i = 2'b00;
    for (int i = 0; i < 9; i++) begin
      step();
      compared++;
      if ({clk_o, tick_o, run_o} !== {exp_clk, exp_tick, exp_run}) begin
        mismatched++;
        $display("FAIL drain_model cyc %0d: got clk=%b tick=%b run=%b want clk=%b tick=%b run=%b",
                 i, clk_o, tick_o, run_o, exp_clk, exp_tick, exp_run);
      end
      compared++;
      if (run_o[0] !== (i < 5) || clk_o[0] !== (i < 2)) begin
        mismatched++;
        $display("FAIL drain_end cyc %0d: got run=%b clk=%b want run=%b clk=%b",
                 i, run_o[0], clk_o[0], (i < 5), (i < 2));
      end
    end
    en_i = 2'b01;
    step();
    en_i = 2'b00;
    step(); step(); step();
    en_i = 2'b01;
    for (int i = 0; i < 14; i++) begin
      step();
      compared++;
      if (run_o[0] !== 1'b1 || clk_o[0] !== ((i + 4) % 6 < 3) ||
          {clk_o, tick_o, run_o} !== {exp_clk, exp_tick, exp_run}) begin
        mismatched++;
        $display("FAIL drain_resume cyc %0d: got clk=%b tick=%b run=%b want clk=%b tick=%b run=%b",
                 i, clk_o, tick_o, run_o, exp_clk, exp_tick, exp_run);
      end
    end
  endtask

  task automatic test_sync();
    do_reset();
    div_i = {WIDTH'(9), WIDTH'(6)};
    en_i  = 2'b11;
    repeat ($urandom_range(3, 20)) step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    compared++;
    if (clk_o !== 2'b11 || tick_o !== 2'b11) begin
      mismatched++;
      $display("FAIL sync_align: got clk=%b tick=%b want clk=11 tick=11", clk_o, tick_o);
    end
    for (int i = 1; i <= 18; i++) begin
      step();
      compared++;
      if ({clk_o, tick_o, run_o} !== {exp_clk, exp_tick, exp_run}) begin
        mismatched++;
        $display("FAIL sync_model cyc %0d: got clk=%b tick=%b run=%b want clk=%b tick=%b run=%b",
                 i, clk_o, tick_o, run_o, exp_clk, exp_tick, exp_run);
      end
    end
    compared++;
    if (tick_o !== 2'b11 || clk_o !== 2'b11) begin
      mismatched++;
      $display("FAIL sync_realign_18: got clk=%b tick=%b want clk=11 tick=11", clk_o, tick_o);
    end
    step(); step();
    en_i   = 2'b01;
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    compared++;
    if (clk_o !== 2'b01 || tick_o !== 2'b01 || run_o !== 2'b01) begin
      mismatched++;
      $display("FAIL sync_idle: got clk=%b tick=%b run=%b want clk=01 tick=01 run=01",
               clk_o, tick_o, run_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    div_i = {WIDTH'(3), WIDTH'(8)};
    en_i  = 2'b11;
    step(); step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compared++;
    if ({clk_o, tick_o, run_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid: got clk=%b tick=%b run=%b want all 0", clk_o, tick_o, run_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      compared++;
      if (clk_o[0] !== (i % 8 < 4) || {clk_o, tick_o, run_o} !== {exp_clk, exp_tick, exp_run}) begin
        mismatched++;
        $display("FAIL reset_restart cyc %0d: got clk=%b tick=%b run=%b want clk=%b tick=%b run=%b",
                 i, clk_o, tick_o, run_o, exp_clk, exp_tick, exp_run);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 7) == 0) div_i[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 12));
        if ($urandom_range(0, 11) == 0) en_i[k] = ~en_i[k];
      end
      sync_i = ($urandom_range(0, 39) == 0);
      step();
      compared++;
      if ({clk_o, tick_o, run_o} !== {exp_clk, exp_tick, exp_run}) begin
        mismatched++;
        $display("FAIL random cyc %0d: got clk=%b tick=%b run=%b want clk=%b tick=%b run=%b",
                 i, clk_o, tick_o, run_o, exp_clk, exp_tick, exp_run);
      end
    end
    sync_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_div4();
    test_odd_and_clamp();
    test_div_change();
    test_drain();
    test_sync();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- Parametrised multi-channel integer clock divider; successor to the single-channel ADC clock divider.
- Each channel produces a divided clock-enable-style output from the system clock, with:
  - runtime divisor,
  - glitch-free divisor update at period boundaries,
  - clean start/stop,
  - a rising-edge strobe.
- Feeds ADC sample clocks and metering sample strobes.
- A shared sync input phase-aligns all channels.

Parameters:
- NCH, 2, number of independent divider channels.
- WIDTH, 13, divisor and counter width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- div_i  input  NCH*WIDTH  per-channel divisor N; channel k uses bits [k*WIDTH +: WIDTH]
- en_i  input  NCH  per-channel run enable
- sync_i  input  1  synchronous restart of all channels, single-cycle pulse
- clk_o  output  NCH  divided clock per channel, registered
- tick_o  output  NCH  one-cycle strobe in the first high cycle of each clk_o period
- run_o  output  NCH  channel state is RUN or DRAIN

Behaviour:
- Reset (async, rst_n=0):
  - clk_o=0, tick_o=0, run_o=0.
  - All counters 0, all channels IDLE, latched divisors 2.
- Effective divisor:
  - Neff = div if div>=2, else 2 (div 0 and 1 are clamped).
  - Period is exactly Neff clk cycles.
  - High phase H = ceil(Neff/2) cycles, low phase L = floor(Neff/2).
  - Odd Neff: high exceeds low by one cycle.
- Per-channel counter cnt runs 0..Neff-1. clk_o=1 while cnt<H, else 0.
- Divisor latching:
  - The latched divisor is loaded from div_i only at a period start: IDLE->RUN, the boundary wrap, or a sync restart.
  - Changes to div_i mid-period have no effect until the next boundary.
- State machine per channel:
  - IDLE: clk_o=0, cnt=0.
    - en_i=1 -> RUN next cycle, with cnt=0, clk_o=1, tick_o=1, divisor latched (one-cycle latency from en_i sampled high).
  - RUN: cnt increments each cycle.
    - At cnt=Neff-1: wrap to cnt=0, clk_o=1, tick_o=1, reload divisor.
    - en_i=0 -> DRAIN with no change to counting.
  - DRAIN: continues the current period unchanged.
    - en_i=1 -> back to RUN with no phase disturbance.
    - Reaching cnt=Neff-1 with en_i=0 -> IDLE next cycle (clk_o=0, run_o=0, no tick).
    - clk_o therefore never truncates a high or low phase.
- sync_i=1 (applies to all channels simultaneously; overrides the boundary and en logic that cycle):
  - Channels with en_i=1: next cycle cnt=0, clk_o=1, tick_o=1, divisor reloaded, state RUN.
  - Channels with en_i=0: forced to IDLE immediately (clk_o=0 next cycle).
  - Afterwards, channels with equal Neff are in phase, and channels with differing Neff share the same rising edge at the sync point.
- Simultaneous events:
  - sync_i at a boundary: treat as sync; the outcome is identical.
  - en_i falling exactly at the boundary cycle in RUN: treat as DRAIN at cnt=0, so one full final period follows.
- tick_o is high for exactly one cycle per period, coincident with the clk_o 0->1 transition.
- Reset mid-operation: all outputs drop to 0 asynchronously; after release, behaviour is as from power-up.
- Arithmetic: counter compares are done at WIDTH bits. Max Neff = 2^WIDTH-1; no overflow at wrap.
- Channels are fully independent except for the shared sync_i.

Test Plan:
- div=4, en=1 from reset:
  - clk_o pattern 1,1,0,0 repeating.
  - tick_o one cycle every 4.
  - First clk_o=1 one cycle after en sampled.
- div=5: clk_o 1,1,1,0,0 repeating; tick period 5. div=0 and div=1: period 2, pattern 1,0.
- div 4 -> 6 changed at cnt=1:
  - Current period completes at 4 cycles.
  - Next period is 1,1,1,0,0,0.
  - No glitch, no short phase.
- en dropped at cnt=0 with div=6:
  - Full 6-cycle period completes, then clk_o stays 0 and run_o falls.
  - en reasserted during DRAIN at cnt=3: continuous output, no phase shift.
- ch0 div=6, ch1 div=9, sync_i pulse:
  - Both clk_o rise and tick on the next cycle.
  - Both rise together again 18 cycles later.
  - A channel with en=0 goes idle on sync.
- rst_n asserted mid high phase: clk_o, tick_o, run_o go 0 immediately; after release with en=1, first period starts with a full high phase.
